wb_arbiter_pipe: RTL and testbench

- Parametrised write-back collector: NUM_CH producer channels (systolic-array pooling outputs) each push {addr, data} into a private FIFO.
- A selectable round-robin / fixed-priority arbiter drains the FIFOs into one registered SRAM write port.
- Adds sink backpressure (sram_wr_ready), producer almost-full/full flow control, overflow detection and an idle flag.
- Sits between the SA array and the output SRAM.

---
 rtl/wb_arbiter_pipe.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_pipe.sv
// Write-back collector: per-channel FIFOs drained by a round-robin / fixed-priority
// arbiter into a single registered valid/ready SRAM write stage.
module wb_arbiter_pipe #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int WB_W       = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_TH   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        ch_wr_en,
  input  logic [NUM_CH*ADDR_W-1:0] ch_wr_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]        ch_afull,
  output logic [NUM_CH-1:0]        ch_full,
  input  logic                     arb_mode,
  output logic                     sram_wr_en,
  output logic [ADDR_W-1:0]        sram_wr_addr,
  output logic [WB_W-1:0]          sram_wr_data,
  input  logic                     sram_wr_ready,
  output logic [NUM_CH-1:0]        ovf_err,
  input  logic                     ovf_clr,
  output logic                     idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  arb_mode_e mode;
  assign mode = arb_mode_e'(arb_mode);

  logic [ENT_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NUM_CH];
  logic [PTR_W-1:0] rd_ptr [NUM_CH];
  logic [CNT_W-1:0] count  [NUM_CH];

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;
  logic [CH_W:0]     rr_sum;
  logic              grant_valid;
  logic              loadable;
  logic [ENT_W-1:0]  head;

  always_comb begin
    ch_full  = '0;
    ch_afull = '0;
    nonempty = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_full[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
      ch_afull[i] = (count[i] >= CNT_W'(AFULL_TH));
      nonempty[i] = (count[i] != '0);
    end
  end

  // Full is taken from registered count, so a same-cycle pop never admits a push.
  assign push     = ch_wr_en & ~ch_full;
  assign loadable = !sram_wr_en || sram_wr_ready;
  assign idle     = !sram_wr_en && (nonempty == '0);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    rr_sum      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      rr_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (rr_sum >= (CH_W+1)'(NUM_CH))
        rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      cand = (mode == ARB_FIXED) ? CH_W'(k) : rr_sum[CH_W-1:0];
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (loadable && grant_valid)
      pop[grant_idx] = 1'b1;
  end

  assign head = mem[grant_idx][rd_ptr[grant_idx]];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= {ch_wr_addr[i*ADDR_W +: ADDR_W], ch_wr_data[i*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sram_wr_en   <= 1'b0;
      sram_wr_addr <= '0;
      sram_wr_data <= '0;
      rr_ptr       <= '0;
      ovf_err      <= '0;
    end else begin
      if (loadable) begin
        sram_wr_en <= grant_valid;
        if (grant_valid) begin
          sram_wr_addr <= head[ENT_W-1:DATA_W];
          sram_wr_data <= WB_W'(head[DATA_W-1:0]);
        end
      end
      if (loadable && grant_valid && mode == ARB_RR)
        rr_ptr <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
      // A new overflow in the clearing cycle survives the clear.
      ovf_err <= (ovf_clr ? '0 : ovf_err) | (ch_wr_en & ch_full);
    end
  end

endmodule

// File: tb/tb_wb_arbiter_pipe.sv
// Scoreboard bench for wb_arbiter_pipe: expected writes are queued at push time
// and compared as the SRAM port fires.
module tb_wb_arbiter_pipe;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 12;
  localparam int WB_W       = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int AFULL_TH   = 12;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NUM_CH-1:0]        ch_wr_en;
  logic [NUM_CH*ADDR_W-1:0] ch_wr_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wr_data;
  logic [NUM_CH-1:0]        ch_afull;
  logic [NUM_CH-1:0]        ch_full;
  logic                     arb_mode;
  logic                     sram_wr_en;
  logic [ADDR_W-1:0]        sram_wr_addr;
  logic [WB_W-1:0]          sram_wr_data;
  logic                     sram_wr_ready;
  logic [NUM_CH-1:0]        ovf_err;
  logic                     ovf_clr;
  logic                     idle;

  wb_arbiter_pipe #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_W(WB_W),
    .FIFO_DEPTH(FIFO_DEPTH), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr), .ch_wr_data(ch_wr_data),
    .ch_afull(ch_afull), .ch_full(ch_full), .arb_mode(arb_mode),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_ready(sram_wr_ready), .ovf_err(ovf_err), .ovf_clr(ovf_clr), .idle(idle)
  );

  always #5 clk = ~clk;

  logic [ADDR_W+WB_W-1:0] sb [$];
  logic [ADDR_W+WB_W-1:0] mon_e;
  int n_checks = 0;
  int n_pass   = 0;
  bit sb_on    = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ch_wr_en[ch] = 1'b1;
    ch_wr_addr[ch*ADDR_W +: ADDR_W] = a;
    ch_wr_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    sb.push_back({a, WB_W'(d)});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, idle, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_en"},    sram_wr_en, 0);
    check_eq({tag, "_addr"},  sram_wr_addr, 0);
    check_eq({tag, "_data"},  sram_wr_data, 0);
    check_eq({tag, "_ovf"},   ovf_err, 0);
    check_eq({tag, "_full"},  ch_full, 0);
    check_eq({tag, "_afull"}, ch_afull, 0);
    check_eq({tag, "_idle"},  idle, 1);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    ch_wr_en = '0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb_on && resetn && sram_wr_en && sram_wr_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_extra_write", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_addr", sram_wr_addr, mon_e[ADDR_W+WB_W-1:WB_W]);
        check_eq("sb_data", sram_wr_data, mon_e[WB_W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int occ;
    bit stg;
    bit acc;
    bit ovf_m;
    bit seen3;

    resetn = 1'b0; ch_wr_en = '0; ch_wr_addr = '0; ch_wr_data = '0;
    arb_mode = 1'b0; sram_wr_ready = 1'b1; ovf_clr = 1'b0;
    tick();
    check_reset_state("rst");
    tick();
    resetn = 1'b1;
    sb_on  = 1'b1;

    // Single push on ch2: one-cycle latency, zero-extended data.
    set_ch(2, 12'h05A, 16'h1234);
    expect_wr(12'h05A, 16'h1234);
    tick();
    ch_wr_en = '0;
    check_eq("t1_en_latency", sram_wr_en, 0);
    check_eq("t1_not_idle", idle, 0);
    tick();
    check_eq("t1_en", sram_wr_en, 1);
    check_eq("t1_addr", sram_wr_addr, 12'h05A);
    check_eq("t1_data", sram_wr_data, 32'h0000_1234);
    tick();
    check_eq("t1_en_off", sram_wr_en, 0);
    check_eq("t1_idle", idle, 1);

    // Two back-to-back bursts on all channels, round-robin from pointer 0.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        set_ch(c, ADDR_W'(c*16 + b), DATA_W'(16'hA000 + c*16 + b));
      end
      tick();
    end
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < NUM_CH; c++)
        expect_wr(ADDR_W'(c*16 + b), DATA_W'(16'hA000 + c*16 + b));
    ch_wr_en = '0;
    for (int k = 0; k < 7; k++) begin
      check_eq("t2_b2b_en", sram_wr_en, 1);
      tick();
    end
    tick();
    check_eq("t2_done_en", sram_wr_en, 0);
    check_eq("t2_idle", idle, 1);

    // Stall: stage must hold while ready is low, then drain back-to-back.
    sram_wr_ready = 1'b0;
    set_ch(0, 12'h100, 16'h0111);
    set_ch(1, 12'h101, 16'h0222);
    expect_wr(12'h100, 16'h0111);
    expect_wr(12'h101, 16'h0222);
    tick();
    ch_wr_en = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("t3_hold_en", sram_wr_en, 1);
      check_eq("t3_hold_addr", sram_wr_addr, 12'h100);
      check_eq("t3_hold_data", sram_wr_data, 32'h0000_0111);
      check_eq("t3_hold_idle", idle, 0);
    end
    sram_wr_ready = 1'b1;
    tick();
    check_eq("t3_next_en", sram_wr_en, 1);
    check_eq("t3_next_addr", sram_wr_addr, 12'h101);
    wait_idle("t3_drain", 10);

    // Fill ch1 past capacity with the sink stalled.
    sram_wr_ready = 1'b0;
    occ = 0; stg = 1'b0; ovf_m = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      ch_wr_en = '0;
      set_ch(1, ADDR_W'(12'h200 + k), DATA_W'(16'h3000 + k));
      acc = (occ < FIFO_DEPTH);
      if (acc) expect_wr(ADDR_W'(12'h200 + k), DATA_W'(16'h3000 + k));
      tick();
      if (!stg && occ > 0) begin
        occ--;
        stg = 1'b1;
      end
      if (acc) occ++;
      else ovf_m = 1'b1;
      check_eq("t4_afull", ch_afull[1], occ >= AFULL_TH);
      check_eq("t4_full", ch_full[1], occ == FIFO_DEPTH);
      check_eq("t4_ovf", ovf_err[1], ovf_m);
    end
    ch_wr_en = '0;
    ovf_clr  = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("t4_ovf_clr", ovf_err, 0);
    ovf_clr = 1'b1;
    set_ch(1, 12'h2FF, 16'hDEAD);
    tick();
    ovf_clr  = 1'b0;
    ch_wr_en = '0;
    check_eq("t4_ovf_set_wins", ovf_err, 4'b0010);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("t4_ovf_clr2", ovf_err, 0);
    check_eq("t4_still_full", ch_full[1], 1);
    sram_wr_ready = 1'b1;
    wait_idle("t4_drain", 40);
    check_eq("t4_sb_empty", sb.size(), 0);

    // Fixed priority starves ch3; switching to round-robin serves it promptly.
    sb_on    = 1'b0;
    arb_mode = 1'b1;
    for (int k = 0; k < 12; k++) begin
      ch_wr_en = '0;
      set_ch(0, {2'd0, 10'(k)}, DATA_W'(k));
      set_ch(3, {2'd3, 10'(k)}, DATA_W'(k));
      tick();
      if (k > 0) begin
        check_eq("t5_fp_en", sram_wr_en, 1);
        check_eq("t5_fp_ch0", sram_wr_addr[11:10], 0);
      end
    end
    arb_mode = 1'b0;
    seen3    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (sram_wr_en && sram_wr_addr[11:10] == 2'd3) seen3 = 1'b1;
    end
    check_eq("t5_rr_ch3", seen3, 1);
    ch_wr_en = '0;
    wait_idle("t5_drain", 60);

    // Asynchronous reset with queued and staged entries.
    sram_wr_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) set_ch(c, ADDR_W'(12'h300 + c*16 + k), DATA_W'(k));
      tick();
    end
    ch_wr_en = '0;
    check_eq("t6_pre_en", sram_wr_en, 1);
    #2 resetn = 1'b0;
    #1 check_reset_state("t6_async");
    tick();
    tick();
    resetn        = 1'b1;
    sram_wr_ready = 1'b1;
    sb_on         = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check_eq("t6_idle", idle, 1);
    check_eq("t6_no_en", sram_wr_en, 0);
    check_eq("sb_final_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
